// File: rtl/ibex_lsu_resp_assembler.sv
// ---------------------------------------------------------------------------
// ibex_lsu_resp_assembler
//
// Purpose:
//   Tracks accepted LSU data bus requests in order and turns the returning
//   response beats into one registered writeback response per request.
//   Word loads and stores complete on a single beat. Capability loads take
//   two beats (lo word first, then hi word) and are assembled into the raw
//   {tag, hi, lo} capability that feeds the downstream decompressor.
//
// Ports:
//   clk_i, rst_i             clock and synchronous active-high reset
//   req_valid_i, req_type_i  request issue (0 word load, 1 cap load,
//                            2 store, 3 reserved and treated as a store)
//   req_ready_o              high while fewer than MaxOutstanding pending
//   data_rvalid_i            one response beat this cycle
//   data_rdata_i/_rtag_i     beat data word and tag bit
//   data_err_i               beat bus error
//   rf_we_lsu_o              load register-file write enable
//   rf_wdata_int_lsu_o       integer load data (lo word for cap loads)
//   rf_wdata_capmem_lsu_o    raw capability {tag, hi, lo}
//   lsu_resp_valid_o/_err_o  one-cycle completion pulse and its error
//   beat_unexpected_o        pulse for a beat with nothing outstanding
//   outstanding_o            current number of outstanding requests
// ---------------------------------------------------------------------------
module ibex_lsu_resp_assembler #(
  parameter int MaxOutstanding = 2,
  parameter int MemCapWidth    = 65
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  input  logic [1:0]             req_type_i,
  output logic                   req_ready_o,
  input  logic                   data_rvalid_i,
  input  logic [31:0]            data_rdata_i,
  input  logic                   data_rtag_i,
  input  logic                   data_err_i,
  output logic                   rf_we_lsu_o,
  output logic [31:0]            rf_wdata_int_lsu_o,
  output logic [MemCapWidth-1:0] rf_wdata_capmem_lsu_o,
  output logic                   lsu_resp_valid_o,
  output logic                   lsu_resp_err_o,
  output logic                   beat_unexpected_o,
  output logic [2:0]             outstanding_o
);

  localparam int              PtrW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(MaxOutstanding - 1);
  localparam logic [2:0]      MaxCount = 3'(MaxOutstanding);

  localparam logic [1:0] TypeWord  = 2'd0;
  localparam logic [1:0] TypeCap   = 2'd1;
  localparam logic [1:0] TypeStore = 2'd2;

  typedef enum logic {
    StIdle,
    StHi
  } beat_state_e;

  beat_state_e            state_q, state_d;
  logic [2:0]             count_q, count_d;
  logic [PtrW-1:0]        wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]        rdPtr_q, rdPtr_d;
  logic [31:0]            lo_q, lo_d;
  logic                   tag_q, tag_d;
  logic                   err_q, err_d;
  logic                   rfWe_q, rfWe_d;
  logic [31:0]            rfInt_q, rfInt_d;
  logic [MemCapWidth-1:0] rfCap_q, rfCap_d;
  logic                   respValid_q, respValid_d;
  logic                   respErr_q, respErr_d;
  logic                   unexpected_q, unexpected_d;

  logic [1:0]             typeMem_q [MaxOutstanding];
  logic [1:0]             pushType;
  logic [1:0]             headType;
  logic                   accept;
  logic                   beatValid;
  logic                   complete;
  logic                   capErr;

  // Ready comes straight from the registered count, so a completion in the
  // same cycle does not free a slot until the following cycle.
  assign req_ready_o = (count_q < MaxCount);
  assign accept      = req_valid_i & req_ready_o;
  // A beat only belongs to a request that was already outstanding; a request
  // accepted in the same cycle cannot claim it.
  assign beatValid   = data_rvalid_i & (count_q != 3'd0);
  assign pushType    = (req_type_i == 2'd3) ? TypeStore : req_type_i;
  assign headType    = typeMem_q[rdPtr_q];
  assign capErr      = err_q | data_err_i;

  // Type FIFO storage has no reset; the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      typeMem_q[wrPtr_q] <= pushType;
    end
  end

  // Beat state machine and response formation. The lo half of a capability
  // load is parked in lo_q/tag_q/err_q until the hi beat arrives, and an
  // error on the lo beat is carried forward instead of ending the request.
  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    tag_d        = tag_q;
    err_d        = err_q;
    complete     = 1'b0;
    rfWe_d       = 1'b0;
    rfInt_d      = '0;
    rfCap_d      = '0;
    respValid_d  = 1'b0;
    respErr_d    = 1'b0;
    unexpected_d = data_rvalid_i & (count_q == 3'd0);

    if (beatValid) begin
      unique case (state_q)
        StIdle: begin
          if (headType == TypeCap) begin
            lo_d    = data_rdata_i;
            tag_d   = data_rtag_i;
            err_d   = data_err_i;
            state_d = StHi;
          end else begin
            complete    = 1'b1;
            respValid_d = 1'b1;
            respErr_d   = data_err_i;
            if ((headType == TypeWord) && !data_err_i) begin
              rfWe_d  = 1'b1;
              rfInt_d = data_rdata_i;
            end
          end
        end
        StHi: begin
          complete    = 1'b1;
          respValid_d = 1'b1;
          respErr_d   = capErr;
          state_d     = StIdle;
          if (!capErr) begin
            rfWe_d  = 1'b1;
            rfInt_d = lo_q;
            rfCap_d = MemCapWidth'({tag_q & data_rtag_i, data_rdata_i, lo_q});
          end
        end
        default: state_d = StIdle;
      endcase
    end

    wrPtr_d = wrPtr_q;
    if (accept) begin
      wrPtr_d = (wrPtr_q == LastPtr) ? '0 : wrPtr_q + 1'b1;
    end
    rdPtr_d = rdPtr_q;
    if (complete) begin
      rdPtr_d = (rdPtr_q == LastPtr) ? '0 : rdPtr_q + 1'b1;
    end
    count_d = count_q + {2'b00, accept} - {2'b00, complete};
  end

  // State and registered outputs; reset clears everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      count_q      <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      lo_q         <= '0;
      tag_q        <= 1'b0;
      err_q        <= 1'b0;
      rfWe_q       <= 1'b0;
      rfInt_q      <= '0;
      rfCap_q      <= '0;
      respValid_q  <= 1'b0;
      respErr_q    <= 1'b0;
      unexpected_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      lo_q         <= lo_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
      rfWe_q       <= rfWe_d;
      rfInt_q      <= rfInt_d;
      rfCap_q      <= rfCap_d;
      respValid_q  <= respValid_d;
      respErr_q    <= respErr_d;
      unexpected_q <= unexpected_d;
    end
  end

  assign rf_we_lsu_o           = rfWe_q;
  assign rf_wdata_int_lsu_o    = rfInt_q;
  assign rf_wdata_capmem_lsu_o = rfCap_q;
  assign lsu_resp_valid_o      = respValid_q;
  assign lsu_resp_err_o        = respErr_q;
  assign beat_unexpected_o     = unexpected_q;
  assign outstanding_o         = count_q;

endmodule

// File: tb/tb_ibex_lsu_resp_assembler.sv
// ---------------------------------------------------------------------------
// tb_ibex_lsu_resp_assembler
//
// Drives directed scenarios followed by random traffic into the response
// assembler. The reference model keeps a queue of pending request kinds and
// the beats collected for the oldest one; once the oldest request has all its
// beats the expected writeback response is computed from those beats.
// ---------------------------------------------------------------------------
module tb_ibex_lsu_resp_assembler;

  localparam int MaxOut = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        tag;
    logic        err;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic [1:0]  reqType;
  logic        reqReady;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rtag;
  logic        rerr;
  logic        rfWe;
  logic [31:0] rfInt;
  logic [64:0] rfCap;
  logic        respValid;
  logic        respErr;
  logic        unexpected;
  logic [2:0]  outstanding;

  int testsRun;
  int testsFailed;

  // Reference model state
  logic [1:0]  pending[$];
  beat_t       headBeats[$];
  logic        expWe;
  logic [31:0] expInt;
  logic [64:0] expCap;
  logic        expValid;
  logic        expErr;
  logic        expUnexp;

  ibex_lsu_resp_assembler #(
    .MaxOutstanding(MaxOut),
    .MemCapWidth(65)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .req_valid_i          (reqValid),
    .req_type_i           (reqType),
    .req_ready_o          (reqReady),
    .data_rvalid_i        (rvalid),
    .data_rdata_i         (rdata),
    .data_rtag_i          (rtag),
    .data_err_i           (rerr),
    .rf_we_lsu_o          (rfWe),
    .rf_wdata_int_lsu_o   (rfInt),
    .rf_wdata_capmem_lsu_o(rfCap),
    .lsu_resp_valid_o     (respValid),
    .lsu_resp_err_o       (respErr),
    .beat_unexpected_o    (unexpected),
    .outstanding_o        (outstanding)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [64:0] observed,
                             input logic [64:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one clock given this cycle's inputs
  task automatic stepModel(input logic r, input logic rv, input logic [1:0] rt,
                           input logic bv, input beat_t b);
    logic       acceptNow;
    logic [1:0] kind;
    logic       anyErr;
    int         needed;
    acceptNow = rv && (pending.size() < MaxOut);
    expWe = 1'b0; expInt = '0; expCap = '0;
    expValid = 1'b0; expErr = 1'b0; expUnexp = 1'b0;
    if (r) begin
      pending.delete();
      headBeats.delete();
    end else begin
      if (bv) begin
        if (pending.size() == 0) begin
          expUnexp = 1'b1;
        end else begin
          headBeats.push_back(b);
          needed = (pending[0] == 2'd1) ? 2 : 1;
          if (headBeats.size() == needed) begin
            kind   = pending.pop_front();
            anyErr = 1'b0;
            foreach (headBeats[k]) anyErr |= headBeats[k].err;
            expValid = 1'b1;
            expErr   = anyErr;
            if (kind == 2'd0 && !anyErr) begin
              expWe  = 1'b1;
              expInt = headBeats[0].data;
            end else if (kind == 2'd1 && !anyErr) begin
              expWe  = 1'b1;
              expInt = headBeats[0].data;
              expCap = {headBeats[0].tag & headBeats[1].tag, headBeats[1].data, headBeats[0].data};
            end
            headBeats.delete();
          end
        end
      end
      if (acceptNow) pending.push_back((rt == 2'd3) ? 2'd2 : rt);
    end
  endtask

  // One cycle: check what the last edge produced, then drive the next inputs
  task automatic applyStimulus(input logic r, input logic rv, input logic [1:0] rt,
                               input logic bv, input logic [31:0] d,
                               input logic t, input logic e);
    beat_t b;
    @(negedge clk);
    checkOutput("rf_we",       65'(rfWe),        65'(expWe));
    checkOutput("rf_int",      65'(rfInt),       65'(expInt));
    checkOutput("rf_capmem",   rfCap,            expCap);
    checkOutput("resp_valid",  65'(respValid),   65'(expValid));
    checkOutput("resp_err",    65'(respErr),     65'(expErr));
    checkOutput("unexpected",  65'(unexpected),  65'(expUnexp));
    checkOutput("outstanding", 65'(outstanding), 65'(pending.size()));
    checkOutput("ready",       65'(reqReady),    65'(pending.size() < MaxOut));
    rst = r; reqValid = rv; reqType = rt;
    rvalid = bv; rdata = d; rtag = t; rerr = e;
    b.data = d; b.tag = t; b.err = e;
    stepModel(r, rv, rt, bv, b);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [1:0] t);
    applyStimulus(1'b0, 1'b1, t, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [31:0] d, input logic t, input logic e);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, d, t, e);
  endtask

  // Directed scenarios then random traffic
  initial begin
    testsRun = 0; testsFailed = 0;
    rst = 1'b1; reqValid = 1'b0; reqType = 2'd0;
    rvalid = 1'b0; rdata = '0; rtag = 1'b0; rerr = 1'b0;
    expWe = 1'b0; expInt = '0; expCap = '0;
    expValid = 1'b0; expErr = 1'b0; expUnexp = 1'b0;

    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 32'h1234, 1'b1, 1'b0);
    idleCycle();

    // Word load
    issue(2'd0);
    beat(32'hDEADBEEF, 1'b0, 1'b0);
    idleCycle();
    // Capability load, both tags set
    issue(2'd1);
    beat(32'h11112222, 1'b1, 1'b0);
    beat(32'h33334444, 1'b1, 1'b0);
    idleCycle();
    idleCycle();
    // Capability load, hi tag clear
    issue(2'd1);
    beat(32'hAAAA5555, 1'b1, 1'b0);
    beat(32'h5555AAAA, 1'b0, 1'b0);
    idleCycle();
    // Capability load, error on lo beat
    issue(2'd1);
    beat(32'hCAFEF00D, 1'b1, 1'b1);
    beat(32'h0BADC0DE, 1'b1, 1'b0);
    idleCycle();
    // Store and reserved type
    issue(2'd2);
    beat(32'hFFFFFFFF, 1'b0, 1'b0);
    issue(2'd3);
    beat(32'h12345678, 1'b0, 1'b1);
    idleCycle();
    // Fill to capacity, stall a third, drain in order
    issue(2'd0);
    issue(2'd2);
    issue(2'd0);
    beat(32'h00000001, 1'b0, 1'b0);
    issue(2'd0);
    beat(32'h00000002, 1'b0, 1'b0);
    beat(32'h00000003, 1'b0, 1'b0);
    idleCycle();
    // Beats with nothing outstanding, including one alongside a request
    beat(32'h99999999, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 32'h77777777, 1'b0, 1'b0);
    beat(32'h88888888, 1'b0, 1'b0);
    idleCycle();
    // Reset in the middle of a capability load
    issue(2'd1);
    beat(32'h44445555, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    beat(32'h66667777, 1'b1, 1'b0);
    idleCycle();

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    $urandom,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0));
    end
    idleCycle();
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
